// File: rtl/wf_rgb_pkg.sv
// Shared types and constants for the RGB dot-matrix serial frame receiver.
// A frame is {green, red, blue, row_sel}; row_sel is active low.
package wf_rgb_pkg;

  localparam int FRAME_BITS_DEF = 32;

  localparam int GRN_MSB = 31;
  localparam int RED_MSB = 23;
  localparam int BLU_MSB = 15;
  localparam int ROW_MSB = 7;

  localparam logic [7:0] ROW_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] idx;
  } row_dec_t;

  // Exactly one zero bit selects a row; anything else decodes to index 0.
  function automatic row_dec_t decode_row(input logic [7:0] row);
    row_dec_t dec;
    int       zeros;
    dec   = '0;
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      if (!row[i]) begin
        zeros   = zeros + 1;
        dec.idx = 3'(i);
      end
    end
    dec.ok = (zeros == 1);
    if (!dec.ok) dec.idx = '0;
    return dec;
  endfunction

endpackage

// File: rtl/wf_sync_edge.sv
// Multi-flop synchronizer followed by one edge-detect flop.
// STAGES = 0 bypasses the synchronizer for same-clock loopback.
module wf_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic prev;

  generate
    if (STAGES == 0) begin : g_bypass
      assign sync = d;
    end else begin : g_sync
      logic [STAGES-1:0] chain;

      // NOTE: sequential state uses <= so every flop samples pre-edge values;
      // blocking assignments here would collapse the chain into one flop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain <= {STAGES{INIT}};
        end else begin
          chain[0] <= d;
          for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
      end

      assign sync = chain[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= INIT;
    else        prev <= sync;
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/wf_rgb_frame_rx.sv
// Receiver for the CLK/DOUT/LOAD RGB scan-frame interface: shifts in one
// frame per LOAD-low window, checks its length and decodes the row select.
module wf_rgb_frame_rx
  import wf_rgb_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023,
  parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ser_clk,
  input  logic        ser_dout,
  input  logic        ser_load,
  output logic        frame_valid,
  output logic [7:0]  green,
  output logic [7:0]  red,
  output logic [7:0]  blue,
  output logic [7:0]  row_sel,
  output logic [2:0]  row_idx,
  output logic        row_ok,
  output logic        len_err,
  output logic        timeout_err,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam logic [5:0]  BIT_CNT_MAX = 6'd63;
  localparam logic [15:0] WD_LAST     = 16'(TIMEOUT - 1);

  logic clk_sync, clk_rise, clk_fall;
  logic dout_sync, dout_rise, dout_fall;
  logic load_sync, load_rise, load_fall;

  wf_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_clk (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ser_clk),
    .sync (clk_sync),
    .rise (clk_rise),
    .fall (clk_fall)
  );

  wf_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_dout (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ser_dout),
    .sync (dout_sync),
    .rise (dout_rise),
    .fall (dout_fall)
  );

  // LOAD idles high, so its synchronizer presets to 1 to avoid a false fall.
  wf_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_load (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ser_load),
    .sync (load_sync),
    .rise (load_rise),
    .fall (load_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{clk_sync, clk_fall, dout_rise, dout_fall, load_sync};

  state_t      state, state_next;
  logic [31:0] shift_q;
  logic [5:0]  bit_cnt;
  logic [15:0] wd;
  logic        wd_expire;
  logic        len_good;
  row_dec_t    row_dec;

  assign len_good = (int'(bit_cnt) == FRAME_BITS);
  assign row_dec  = decode_row(shift_q[ROW_MSB -: 8]);
  assign busy     = (state == SHIFT);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    wd_expire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_fall) state_next = SHIFT;
      end
      SHIFT: begin
        if (load_rise) begin
          state_next = DONE;
        end else if (!clk_rise && wd == WD_LAST) begin
          state_next = IDLE;
          wd_expire  = 1'b1;
        end
      end
      DONE: begin
        state_next = load_fall ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Shift register, bit counter and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
      wd      <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (load_fall) begin
            bit_cnt <= '0;
            wd      <= '0;
          end
        end
        SHIFT: begin
          // A bit arriving with the LOAD rise is still part of this frame.
          if (clk_rise) begin
            shift_q <= {shift_q[30:0], dout_sync};
            if (bit_cnt != BIT_CNT_MAX) bit_cnt <= bit_cnt + 6'd1;
            wd <= '0;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame outputs only move on a good frame; errors are bare pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      green       <= '0;
      red         <= '0;
      blue        <= '0;
      row_sel     <= '0;
      row_idx     <= '0;
      row_ok      <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_valid <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= wd_expire;
      if (state == DONE) begin
        if (len_good) begin
          frame_valid <= 1'b1;
          green       <= shift_q[GRN_MSB -: 8];
          red         <= shift_q[RED_MSB -: 8];
          blue        <= shift_q[BLU_MSB -: 8];
          row_sel     <= shift_q[ROW_MSB -: 8];
          row_idx     <= row_dec.idx;
          row_ok      <= row_dec.ok;
          frame_count <= frame_count + 16'd1;
        end else begin
          len_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wf_rgb_frame_rx.sv
// Randomized self-checking bench: dut_a (2-stage sync, TIMEOUT 16) and
// dut_b (sync bypass) share the serial pins; a queue-based model predicts frames.
module tb_wf_rgb_frame_rx;
  import wf_rgb_pkg::*;

  localparam int TO     = 16;
  localparam int SYNC_A = 2;

  typedef struct packed {
    logic [7:0]  g;
    logic [7:0]  r;
    logic [7:0]  b;
    logic [7:0]  row;
    logic [2:0]  idx;
    logic        ok;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_clk = 1'b0;
  logic ser_dout = 1'b0;
  logic ser_load = 1'b1;

  logic        a_fv, a_row_ok, a_len, a_to, a_busy;
  logic [7:0]  a_green, a_red, a_blue, a_row_sel;
  logic [2:0]  a_row_idx;
  logic [15:0] a_fc;
  logic        b_fv, b_row_ok, b_len, b_to, b_busy;
  logic [7:0]  b_green, b_red, b_blue, b_row_sel;
  logic [2:0]  b_row_idx;
  logic [15:0] b_fc;

  int total = 0;
  int bad = 0;
  int now_cyc = 0;
  int n_len_a = 0, n_to_a = 0, n_len_b = 0, n_to_b = 0;
  int last_to_cyc_a = 0;
  obs_t a_q[$];
  obs_t b_q[$];
  obs_t exp_a;
  int fc_a = 0;

  wf_rgb_frame_rx #(.SYNC_STAGES(SYNC_A), .TIMEOUT(TO), .FRAME_BITS(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_dout(ser_dout), .ser_load(ser_load),
    .frame_valid(a_fv), .green(a_green), .red(a_red), .blue(a_blue), .row_sel(a_row_sel),
    .row_idx(a_row_idx), .row_ok(a_row_ok), .len_err(a_len), .timeout_err(a_to),
    .busy(a_busy), .frame_count(a_fc)
  );

  wf_rgb_frame_rx #(.SYNC_STAGES(0), .TIMEOUT(TO), .FRAME_BITS(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_dout(ser_dout), .ser_load(ser_load),
    .frame_valid(b_fv), .green(b_green), .red(b_red), .blue(b_blue), .row_sel(b_row_sel),
    .row_idx(b_row_idx), .row_ok(b_row_ok), .len_err(b_len), .timeout_err(b_to),
    .busy(b_busy), .frame_count(b_fc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) now_cyc <= now_cyc + 1;

  always @(negedge clk) begin
    if (a_fv) a_q.push_back({a_green, a_red, a_blue, a_row_sel, a_row_idx, a_row_ok, a_fc});
    if (b_fv) b_q.push_back({b_green, b_red, b_blue, b_row_sel, b_row_idx, b_row_ok, b_fc});
    if (a_len) n_len_a++;
    if (b_len) n_len_b++;
    if (a_to) begin
      n_to_a++;
      last_to_cyc_a = now_cyc;
    end
    if (b_to) n_to_b++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench time limit");
  end

  // Expected observation for a good 32-bit frame, from the row-select rules.
  function automatic obs_t model_good(input logic [31:0] f, input int fc);
    obs_t       o;
    logic [7:0] z;
    o.g   = f[31:24];
    o.r   = f[23:16];
    o.b   = f[15:8];
    o.row = f[7:0];
    z     = ~f[7:0];
    o.ok  = (z != 8'd0) && ((z & (z - 8'd1)) == 8'd0);
    o.idx = o.ok ? 3'($clog2(z)) : 3'd0;
    o.fc  = 16'(fc);
    return o;
  endfunction

  function automatic obs_t held_a();
    return {a_green, a_red, a_blue, a_row_sel, a_row_idx, a_row_ok, a_fc};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    ser_load = 1'b1;
    ser_clk  = 1'b0;
    ser_dout = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    fc_a  = 0;
    exp_a = '0;
  endtask

  task automatic send_frame(input logic [63:0] data, input int n, input int half);
    ser_load = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      ser_dout = data[i % 64];
      ser_clk  = 1'b0;
      cyc(half);
      ser_clk = 1'b1;
      cyc(half);
    end
    ser_clk  = 1'b0;
    ser_load = 1'b1;
    cyc(half);
  endtask

  task automatic run_frame_a(input logic [63:0] data, input int n, input int half,
                             output int nfv, output int nlen, output int nto, output obs_t got);
    int q0, l0, t0;
    q0 = a_q.size();
    l0 = n_len_a;
    t0 = n_to_a;
    send_frame(data, n, half);
    cyc(12);
    nfv  = a_q.size() - q0;
    nlen = n_len_a - l0;
    nto  = n_to_a - t0;
    got  = (nfv > 0) ? a_q[a_q.size() - 1] : '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    total++;
    if ({a_fv, a_green, a_red, a_blue, a_row_sel, a_row_idx, a_row_ok, a_len, a_to, a_busy, a_fc} !== '0) begin
      bad++;
      $display("FAIL reset_a: got %h required 0", {a_fv, a_green, a_red, a_blue, a_row_sel, a_row_idx, a_row_ok, a_len, a_to, a_busy, a_fc});
    end
    total++;
    if ({b_fv, b_green, b_red, b_blue, b_row_sel, b_row_idx, b_row_ok, b_len, b_to, b_busy, b_fc} !== '0) begin
      bad++;
      $display("FAIL reset_b: got %h required 0", {b_fv, b_green, b_red, b_blue, b_row_sel, b_row_idx, b_row_ok, b_len, b_to, b_busy, b_fc});
    end
    rst_n = 1'b1;
    cyc(3);
    fc_a  = 0;
    exp_a = '0;
  endtask

  task automatic test_basic();
    int nfv, nlen, nto;
    obs_t got;
    run_frame_a({32'h0, 32'h00FF_0FFE}, 32, 2, nfv, nlen, nto, got);
    fc_a++;
    exp_a = model_good(32'h00FF_0FFE, fc_a);
    total++;
    if (nfv !== 1 || nlen !== 0 || nto !== 0) begin
      bad++;
      $display("FAIL basic_pulses: got fv=%0d len=%0d to=%0d required 1/0/0", nfv, nlen, nto);
    end
    total++;
    if (got !== exp_a) begin
      bad++;
      $display("FAIL basic_fields: got %h required %h", got, exp_a);
    end
    total++;
    if (exp_a.idx !== 3'd0 || exp_a.ok !== 1'b1 || a_fc !== 16'd1) begin
      bad++;
      $display("FAIL basic_count: got fc=%0d required 1", a_fc);
    end
  endtask

  task automatic test_len();
    int nfv, nlen, nto;
    obs_t got;
    int lens[3] = '{31, 33, 70};
    foreach (lens[k]) begin
      run_frame_a({$urandom, $urandom}, lens[k], 2, nfv, nlen, nto, got);
      total++;
      if (nfv !== 0 || nlen !== 1 || nto !== 0) begin
        bad++;
        $display("FAIL len_pulses_%0d: got fv=%0d len=%0d to=%0d required 0/1/0", lens[k], nfv, nlen, nto);
      end
      total++;
      if (held_a() !== exp_a) begin
        bad++;
        $display("FAIL len_hold_%0d: got %h required %h", lens[k], held_a(), exp_a);
      end
    end
  endtask

  task automatic test_row_invalid();
    int nfv, nlen, nto;
    obs_t got;
    logic [7:0] rows[2] = '{8'hFC, ROW_IDLE};
    foreach (rows[k]) begin
      logic [31:0] f;
      f = {8'($urandom), 8'($urandom), 8'($urandom), rows[k]};
      run_frame_a({32'h0, f}, 32, 2, nfv, nlen, nto, got);
      fc_a++;
      exp_a = model_good(f, fc_a);
      total++;
      if (nfv !== 1 || nlen !== 0 || got !== exp_a || got.ok !== 1'b0 || got.idx !== 3'd0) begin
        bad++;
        $display("FAIL row_invalid_%h: got fv=%0d len=%0d obs=%h required fv=1 len=0 obs=%h", rows[k], nfv, nlen, got, exp_a);
      end
    end
  endtask

  task automatic test_timeout();
    int q0, l0, t0, start, nfv, nlen, nto;
    obs_t got;
    logic [31:0] f;
    q0 = a_q.size();
    l0 = n_len_a;
    t0 = n_to_a;
    start = 0;
    ser_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ser_dout = 1'($urandom_range(0, 1));
      ser_clk  = 1'b0;
      cyc(2);
      ser_clk = 1'b1;
      start   = now_cyc;
      cyc(2);
    end
    total++;
    if (a_busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_busy_before: got %b required 1", a_busy);
    end
    for (int k = 0; k < 60 && n_to_a == t0; k++) cyc(1);
    total++;
    if (n_to_a - t0 !== 1) begin
      bad++;
      $display("FAIL timeout_pulse: got %0d pulses required 1", n_to_a - t0);
    end
    total++;
    if (last_to_cyc_a - start < TO + 1 || last_to_cyc_a - start > TO + SYNC_A + 3) begin
      bad++;
      $display("FAIL timeout_delay: got %0d cycles required %0d..%0d", last_to_cyc_a - start, TO + 1, TO + SYNC_A + 3);
    end
    cyc(2);
    total++;
    if (a_busy !== 1'b0 || held_a() !== exp_a) begin
      bad++;
      $display("FAIL timeout_after: got busy=%b obs=%h required busy=0 obs=%h", a_busy, held_a(), exp_a);
    end
    ser_load = 1'b1;
    cyc(4);
    ser_clk = 1'b0;
    cyc(4);
    total++;
    if (a_q.size() != q0 || n_len_a != l0 || n_to_a - t0 != 1) begin
      bad++;
      $display("FAIL timeout_quiet: got fv=%0d len=%0d to=%0d required 0/0/1", a_q.size() - q0, n_len_a - l0, n_to_a - t0);
    end
    f = {8'($urandom), 8'($urandom), 8'($urandom), 8'h7F};
    run_frame_a({32'h0, f}, 32, 2, nfv, nlen, nto, got);
    fc_a++;
    exp_a = model_good(f, fc_a);
    total++;
    if (nfv !== 1 || got !== exp_a || got.idx !== 3'd7) begin
      bad++;
      $display("FAIL timeout_recover: got fv=%0d obs=%h required fv=1 obs=%h", nfv, got, exp_a);
    end
  endtask

  task automatic test_random();
    int nfv, nlen, nto, n;
    obs_t got;
    logic [63:0] d;
    logic [31:0] f;
    for (int it = 0; it < 12; it++) begin
      d = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) d[7:0] = ~(8'd1 << $urandom_range(0, 7));
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 40) : 32;
      f = d[31:0];
      run_frame_a(d, n, 2, nfv, nlen, nto, got);
      if (n == 32) begin
        fc_a++;
        exp_a = model_good(f, fc_a);
      end
      total++;
      if (nfv !== (n == 32 ? 1 : 0) || nlen !== (n == 32 ? 0 : 1) || nto !== 0) begin
        bad++;
        $display("FAIL random_%0d_pulses: n=%0d got fv=%0d len=%0d to=%0d", it, n, nfv, nlen, nto);
      end
      total++;
      if (held_a() !== exp_a) begin
        bad++;
        $display("FAIL random_%0d_fields: n=%0d got %h required %h", it, n, held_a(), exp_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    int q0, l0, t0;
    obs_t want[$];
    logic [31:0] f;
    apply_reset();
    q0 = b_q.size();
    l0 = n_len_b;
    t0 = n_to_b;
    for (int k = 0; k < 8; k++) begin
      f = {8'($urandom), 8'($urandom), 8'($urandom), ~(8'd1 << k)};
      want.push_back(model_good(f, k + 1));
      send_frame({32'h0, f}, 32, 1);
    end
    cyc(10);
    total++;
    if (b_q.size() - q0 !== 8 || n_len_b != l0 || n_to_b != t0) begin
      bad++;
      $display("FAIL b2b_pulses: got fv=%0d len=%0d to=%0d required 8/0/0", b_q.size() - q0, n_len_b - l0, n_to_b - t0);
    end
    for (int k = 0; k < 8 && q0 + k < b_q.size(); k++) begin
      total++;
      if (b_q[q0 + k] !== want[k]) begin
        bad++;
        $display("FAIL b2b_frame_%0d: got %h required %h", k, b_q[q0 + k], want[k]);
      end
    end
    total++;
    if (b_fc !== 16'd8) begin
      bad++;
      $display("FAIL b2b_count: got %0d required 8", b_fc);
    end
  endtask

  task automatic test_reset_mid_frame();
    int nfv, nlen, nto, l0, t0;
    obs_t got;
    logic [31:0] f;
    apply_reset();
    l0 = n_len_a;
    t0 = n_to_a;
    ser_load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ser_dout = 1'($urandom_range(0, 1));
      ser_clk  = 1'b0;
      cyc(2);
      ser_clk = 1'b1;
      cyc(2);
    end
    rst_n = 1'b0;
    cyc(1);
    total++;
    if (a_busy !== 1'b0 || a_fc !== 16'd0) begin
      bad++;
      $display("FAIL midreset_state: got busy=%b fc=%0d required 0/0", a_busy, a_fc);
    end
    ser_clk  = 1'b0;
    ser_load = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    f = {8'($urandom), 8'($urandom), 8'($urandom), ~(8'd1 << $urandom_range(0, 7))};
    run_frame_a({32'h0, f}, 32, 2, nfv, nlen, nto, got);
    exp_a = model_good(f, 1);
    total++;
    if (n_len_a != l0 || n_to_a != t0) begin
      bad++;
      $display("FAIL midreset_errors: got len=%0d to=%0d required 0/0", n_len_a - l0, n_to_a - t0);
    end
    total++;
    if (nfv !== 1 || got !== exp_a || a_fc !== 16'd1) begin
      bad++;
      $display("FAIL midreset_frame: got fv=%0d obs=%h required fv=1 obs=%h", nfv, got, exp_a);
    end
  endtask

  initial begin
    exp_a = '0;
    test_reset();
    test_basic();
    test_len();
    test_row_invalid();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
